// File: rtl/of_defs.sv
// of_defs: shared state encodings and counter width for of_input_arbiter
package of_defs;
  typedef enum logic [1:0] {ARB_IDLE, ARB_HDR, ARB_PAYLOAD} arb_state_t;
  localparam int PKT_CNT_WIDTH = 32;
endpackage

// File: rtl/of_rr_select.sv
// of_rr_select: combinational round-robin picker, first requester at or above ptr with wrap
module of_rr_select #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          valid
);
  logic [2*N-1:0] rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;
  always_comb begin
    rot = {req, req} >> ptr;
    off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = IW'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    winner = sum >= (IW+1)'(N) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    valid = |req;
  end
endmodule

// File: rtl/of_input_arbiter.sv
// of_input_arbiter: packet-granular round-robin merge of NUM_INPUTS streams, 1-cycle registered output.
// Define OF_ARB_PKT_CNT_EN to add per-input forwarded-packet counters on pkt_cnt.
module of_input_arbiter
  import of_defs::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_INPUTS = 4,
  parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_INPUTS-1:0]          in_wr,
  input  logic [NUM_INPUTS-1:0]          in_req,
  output logic [NUM_INPUTS-1:0]          in_rdy,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CTRL_WIDTH-1:0]          out_ctrl,
  output logic                           out_wr,
  input  logic                           out_rdy,
  output logic [IDX_WIDTH-1:0]           grant_idx
`ifdef OF_ARB_PKT_CNT_EN
  ,
  output logic [NUM_INPUTS*PKT_CNT_WIDTH-1:0] pkt_cnt
`endif
);
  arb_state_t            state;
  logic [IDX_WIDTH-1:0]  rr_ptr, winner, next_ptr;
  logic                  req_valid, accept, eop;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [CTRL_WIDTH-1:0] sel_ctrl;
  of_rr_select #(.N(NUM_INPUTS), .IW(IDX_WIDTH)) u_rr_select (
    .req   (in_req),
    .ptr   (rr_ptr),
    .winner(winner),
    .valid (req_valid)
  );
  assign sel_data = in_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_ctrl = in_ctrl[grant_idx*CTRL_WIDTH +: CTRL_WIDTH];
  always_comb begin
    in_rdy = '0;
    in_rdy[grant_idx] = (state != ARB_IDLE) & out_rdy;
  end
  assign accept   = in_wr[grant_idx] & in_rdy[grant_idx];
  assign eop      = accept & (state == ARB_PAYLOAD) & (|sel_ctrl);
  assign next_ptr = grant_idx == IDX_WIDTH'(NUM_INPUTS - 1) ? '0 : grant_idx + 1'b1;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      out_wr    <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
    end else begin
      out_wr <= accept;
      if (accept) begin
        out_data <= sel_data;
        out_ctrl <= sel_ctrl;
      end
      case (state)
        ARB_IDLE: if (req_valid) begin
          grant_idx <= winner;
          state     <= ARB_HDR;
        end
        ARB_HDR: if (accept && sel_ctrl == '0) state <= ARB_PAYLOAD;
        ARB_PAYLOAD: if (eop) begin
          state  <= ARB_IDLE;
          rr_ptr <= next_ptr;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
`ifdef OF_ARB_PKT_CNT_EN
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_INPUTS; i++)
      if (!reset) pkt_cnt[i*PKT_CNT_WIDTH +: PKT_CNT_WIDTH] <= '0;
      else if (eop && grant_idx == IDX_WIDTH'(i))
        pkt_cnt[i*PKT_CNT_WIDTH +: PKT_CNT_WIDTH] <= pkt_cnt[i*PKT_CNT_WIDTH +: PKT_CNT_WIDTH] + 1'b1;
`endif
endmodule

// File: tb/tb_of_input_arbiter.sv
// tb_of_input_arbiter: scoreboard bench for of_input_arbiter; define OF_ARB_PKT_CNT_EN to cover pkt_cnt.
module tb_of_input_arbiter;
  localparam int DW = 64, CW = 8, N = 4, IW = 2;
  typedef struct packed { logic [DW-1:0] data; logic [CW-1:0] ctrl; logic first; } word_t;
  typedef struct packed { logic [DW-1:0] data; logic [CW-1:0] ctrl; logic [31:0] cyc; } exp_t;
  logic clk, reset, out_wr, out_rdy;
  logic [N*DW-1:0] in_data;
  logic [N*CW-1:0] in_ctrl;
  logic [N-1:0] in_wr, in_req, in_rdy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [IW-1:0] grant_idx;
`ifdef OF_ARB_PKT_CNT_EN
  logic [N*32-1:0] pkt_cnt;
`endif
  of_input_arbiter dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_req(in_req), .in_rdy(in_rdy), .out_data(out_data), .out_ctrl(out_ctrl),
    .out_wr(out_wr), .out_rdy(out_rdy), .grant_idx(grant_idx)
`ifdef OF_ARB_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  word_t wq[N][$];
  exp_t sb[$];
  logic [7:0] src_log[$];
  int npend[N], pktno[N];
  logic [CW-1:0] last_drv_ctrl[N];
  logic [23:0] last_tag;
  int cyc, total, bad, stall_cnt, nout;
  bit stall_arm, stall_seen, rogue, prev_rdy;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit pending();
    pending = sb.size() > 0;
    for (int i = 0; i < N; i++) if (wq[i].size() > 0) pending = 1'b1;
  endfunction
  task automatic add_pkt(int src, int h, int p);
    word_t x;
    for (int w = 0; w < h + p + 1; w++) begin
      x.data  = {8'(src), 8'(pktno[src]), 8'(w), 8'h00, 32'($urandom())};
      x.ctrl  = w < h ? 8'hFF : (w < h + p ? 8'h00 : 8'h80);
      x.first = (w == 0);
      wq[src].push_back(x);
    end
    pktno[src]++;
    npend[src]++;
  endtask
  task automatic monitor();
    exp_t e;
    if (out_wr) begin
      nout++;
      if (sb.size() == 0) check("extra_word", 64'(out_data), 64'hDEAD);
      else begin
        e = sb.pop_front();
        check("data", out_data, e.data);
        check("ctrl", 64'(out_ctrl), 64'(e.ctrl));
        check("latency", 64'(cyc - int'(e.cyc)), 64'd1);
        if (out_data[47:40] == 8'd0) src_log.push_back(out_data[63:56]);
        else check("contig", 64'(out_data[63:40]), 64'({last_tag[23:8], last_tag[7:0] + 8'd1}));
        last_tag = out_data[63:40];
      end
    end
    if (!prev_rdy) check("stall_out_wr", 64'(out_wr), 64'd0);
  endtask
  task automatic step();
    word_t x;
    @(posedge clk); #1;
    cyc++;
    monitor();
    if (stall_arm && grant_idx == 2'd2 && last_drv_ctrl[2] == 8'h00 && wq[2].size() > 1) begin
      stall_cnt = 5;
      stall_arm = 1'b0;
      stall_seen = 1'b1;
    end
    out_rdy = (stall_cnt == 0);
    if (stall_cnt > 0) stall_cnt--;
    for (int i = 0; i < N; i++) in_req[i] = npend[i] > 0;
    in_wr = '0;
    #1;
    if (!out_rdy) check("stall_in_rdy", 64'(in_rdy), 64'd0);
    for (int i = 0; i < N; i++)
      if (in_rdy[i] && wq[i].size() > 0) begin
        x = wq[i].pop_front();
        in_data[i*DW +: DW] = x.data;
        in_ctrl[i*CW +: CW] = x.ctrl;
        in_wr[i] = 1'b1;
        if (x.first) npend[i]--;
        last_drv_ctrl[i] = x.ctrl;
        sb.push_back('{x.data, x.ctrl, 32'(cyc)});
      end
    if (rogue && !in_rdy[3]) begin
      in_data[3*DW +: DW] = {8'hEE, 24'h0, 32'($urandom())};
      in_ctrl[3*CW +: CW] = 8'h80;
      in_wr[3] = 1'b1;
    end
    prev_rdy = out_rdy;
  endtask
  task automatic run(int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(pending()), 64'd0);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    out_rdy = 1'b1;
    in_req = '1;
    in_wr = '1;
    in_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    in_ctrl = 32'($urandom());
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_out_wr", 64'(out_wr), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      check("rst_in_rdy", 64'(in_rdy), 64'd0);
      check("rst_grant", 64'(grant_idx), 64'd0);
`ifdef OF_ARB_PKT_CNT_EN
      check("rst_pkt_cnt", 64'(pkt_cnt == '0), 64'd1);
`endif
    end
    for (int i = 0; i < N; i++) begin
      wq[i].delete();
      npend[i] = 0;
      last_drv_ctrl[i] = 8'hFF;
    end
    sb.delete();
    src_log.delete();
    in_req = '0;
    in_wr = '0;
    prev_rdy = 1'b1;
    stall_cnt = 0;
    nout = 0;
    reset = 1'b1;
  endtask
  initial begin
    total = 0; bad = 0; cyc = 0;
    stall_arm = 0; stall_seen = 0; rogue = 0; last_tag = '0;
    for (int i = 0; i < N; i++) pktno[i] = 0;
    do_reset();
    add_pkt(0, 2, 4);
    run(100);
    check("single_words", 64'(nout), 64'd7);
    check("single_grant", 64'(grant_idx), 64'd0);
    do_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) add_pkt(i, 1 + i % 2, i + 1);
    run(500);
    check("rr_pkts", 64'(src_log.size()), 64'd12);
    for (int k = 0; k < 12; k++)
      check("rr_order", 64'(k < src_log.size() ? src_log[k] : 8'hFF), 64'(k % 4));
    stall_arm = 1'b1;
    add_pkt(2, 2, 6);
    run(100);
    check("stall_seen", 64'(stall_seen), 64'd1);
    rogue = 1'b1;
    add_pkt(1, 2, 5);
    run(100);
    rogue = 1'b0;
    check("rogue_grant", 64'(grant_idx), 64'd1);
`ifdef OF_ARB_PKT_CNT_EN
    do_reset();
    for (int k = 0; k < 5; k++) add_pkt(1, 1, 2);
    for (int k = 0; k < 2; k++) add_pkt(3, 2, 1);
    run(500);
    step();
    check("cnt0", 64'(pkt_cnt[31:0]), 64'd0);
    check("cnt1", 64'(pkt_cnt[63:32]), 64'd5);
    check("cnt2", 64'(pkt_cnt[95:64]), 64'd0);
    check("cnt3", 64'(pkt_cnt[127:96]), 64'd2);
    do_reset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
